// File: rtl/oled_spi_slave_if.sv
// OLED 4-wire SPI pins plus the receive-side byte stream and status of the slave model.
`timescale 1ns/1ps
interface oled_spi_slave_if;
  logic        OLED_SCLK;
  logic        OLED_CS;
  logic        OLED_DC;
  logic        OLED_DIN;
  logic        OLED_RST;
  logic [7:0]  RX_DATA;
  logic        RX_DC;
  logic        RX_VALID;
  logic        RX_READY;
  logic        RX_OVERFLOW;
  logic        RX_FRAME_ERR;
  logic        ERR_CLR;
  logic        DISPLAY_ON;
  logic [15:0] BYTE_CNT;

  modport slave (
    input  OLED_SCLK, OLED_CS, OLED_DC, OLED_DIN, OLED_RST, RX_READY, ERR_CLR,
    output RX_DATA, RX_DC, RX_VALID, RX_OVERFLOW, RX_FRAME_ERR, DISPLAY_ON, BYTE_CNT
  );

  modport master (
    output OLED_SCLK, OLED_CS, OLED_DC, OLED_DIN, OLED_RST, RX_READY, ERR_CLR,
    input  RX_DATA, RX_DC, RX_VALID, RX_OVERFLOW, RX_FRAME_ERR, DISPLAY_ON, BYTE_CNT
  );
endinterface

// File: rtl/oled_spi_slave.sv
// Display-side SPI receiver: synchronizes the pins, assembles MSB-first bytes tagged
// command/data, queues them in a small FIFO and tracks display on/off and error state.
`timescale 1ns/1ps
module oled_spi_slave #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic             CLK,
  input logic             RST_N,
  oled_spi_slave_if.slave bus
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SW = 5;
  // Sync bit order: {rst, din, dc, cs, sclk}; CS idles high
  localparam logic [SW-1:0] SYNC_RST = 5'b00010;

  typedef enum logic {IDLE, RECV} state_e;

  logic [SW-1:0] sync_q [SYNC_STAGES];
  logic [SW-1:0] sync_d [SYNC_STAGES];

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic       cap_valid_q, cap_valid_d;
  logic [7:0] cap_byte_q, cap_byte_d;
  logic       cap_dc_q, cap_dc_d;
  logic       frame_set_c;

  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [8:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_dc_q, rx_dc_d;
  logic          rx_valid_q, rx_valid_d;
  logic          overflow_q, overflow_d;
  logic          frame_err_q, frame_err_d;
  logic          display_on_q, display_on_d;
  logic [15:0]   byte_cnt_q, byte_cnt_d;

  logic sclk_s, cs_s, dc_s, din_s, rst_s;
  assign sclk_s = sync_q[SYNC_STAGES-1][0];
  assign cs_s   = sync_q[SYNC_STAGES-1][1];
  assign dc_s   = sync_q[SYNC_STAGES-1][2];
  assign din_s  = sync_q[SYNC_STAGES-1][3];
  assign rst_s  = sync_q[SYNC_STAGES-1][4];

  // Synchronizer shift chain for all five SPI-side pins
  always_comb begin
    sync_d[0] = {bus.OLED_RST, bus.OLED_DIN, bus.OLED_DC, bus.OLED_CS, bus.OLED_SCLK};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  // Receive FSM: bit shifting, byte completion, framing check
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sclk_prev_d = sclk_s;
    cap_valid_d = 1'b0;
    cap_byte_d  = cap_byte_q;
    cap_dc_d    = cap_dc_q;
    frame_set_c = 1'b0;
    if (!rst_s) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      shift_d   = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          bit_cnt_d = 3'd0;
          if (!cs_s) state_d = RECV;
        end
        RECV: begin
          if (cs_s) begin
            state_d     = IDLE;
            bit_cnt_d   = 3'd0;
            frame_set_c = (bit_cnt_q != 3'd0);
          end else if (sclk_s && !sclk_prev_q) begin
            shift_d = {shift_q[6:0], din_s};
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d   = 3'd0;
              cap_valid_d = 1'b1;
              cap_byte_d  = {shift_q[6:0], din_s};
              cap_dc_d    = dc_s;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FIFO, head registers, sticky flags, display state and byte counter
  always_comb begin
    logic [PW-1:0] count_now;
    logic [PW-1:0] count_nxt;
    logic          pop;
    logic          full;
    logic          ovf_set;
    logic [8:0]    head;
    mem_d        = mem_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    ovf_set      = 1'b0;
    display_on_d = display_on_q;
    byte_cnt_d   = byte_cnt_q;
    count_now    = PW'(wr_q - rd_q);
    full         = (count_now == PW'(FIFO_DEPTH));
    pop          = rx_valid_q & bus.RX_READY;
    if (cap_valid_q) byte_cnt_d = byte_cnt_q + 16'd1;
    if (!rst_s) begin
      wr_d         = '0;
      rd_d         = '0;
      display_on_d = 1'b0;
    end else begin
      if (pop) rd_d = rd_q + PW'(1);
      if (cap_valid_q) begin
        if (!cap_dc_q && cap_byte_q == 8'hAF) display_on_d = 1'b1;
        if (!cap_dc_q && cap_byte_q == 8'hAE) display_on_d = 1'b0;
        if (!full || pop) begin
          mem_d[wr_q[AW-1:0]] = {cap_dc_q, cap_byte_q};
          wr_d = wr_q + PW'(1);
        end else begin
          ovf_set = 1'b1;
        end
      end
    end
    count_nxt   = PW'(wr_d - rd_d);
    head        = mem_d[rd_d[AW-1:0]];
    rx_valid_d  = (count_nxt != '0);
    // Hold the last head when empty so the outputs stay stable
    rx_data_d   = rx_valid_d ? head[7:0] : rx_data_q;
    rx_dc_d     = rx_valid_d ? head[8]   : rx_dc_q;
    overflow_d  = (overflow_q  & ~bus.ERR_CLR) | ovf_set;
    frame_err_d = (frame_err_q & ~bus.ERR_CLR) | frame_set_c;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 9'd0;
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      sclk_prev_q  <= 1'b0;
      cap_valid_q  <= 1'b0;
      cap_byte_q   <= 8'd0;
      cap_dc_q     <= 1'b0;
      wr_q         <= '0;
      rd_q         <= '0;
      rx_data_q    <= 8'd0;
      rx_dc_q      <= 1'b0;
      rx_valid_q   <= 1'b0;
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      display_on_q <= 1'b0;
      byte_cnt_q   <= 16'd0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      sclk_prev_q  <= sclk_prev_d;
      cap_valid_q  <= cap_valid_d;
      cap_byte_q   <= cap_byte_d;
      cap_dc_q     <= cap_dc_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      rx_data_q    <= rx_data_d;
      rx_dc_q      <= rx_dc_d;
      rx_valid_q   <= rx_valid_d;
      overflow_q   <= overflow_d;
      frame_err_q  <= frame_err_d;
      display_on_q <= display_on_d;
      byte_cnt_q   <= byte_cnt_d;
    end
  end

  assign bus.RX_DATA      = rx_data_q;
  assign bus.RX_DC        = rx_dc_q;
  assign bus.RX_VALID     = rx_valid_q;
  assign bus.RX_OVERFLOW  = overflow_q;
  assign bus.RX_FRAME_ERR = frame_err_q;
  assign bus.DISPLAY_ON   = display_on_q;
  assign bus.BYTE_CNT     = byte_cnt_q;

endmodule
